matrix_vec_mac: RTL and testbench

MATRIX_VEC_MAC -- requirements
Module: matrix_vec_mac

---
 rtl/matrix_vec_mac.sv | 179 +++++++++++++++++
 tb/tb_matrix_vec_mac.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_vec_mac.sv
`default_nettype none
// ============================================================================
// Module   : matrix_vec_mac
// Purpose  : Signed fixed-point matrix-vector multiply-accumulate,
//            Res = A*x, c+A*x or c-A*x. One column per enabled cycle, with
//            all rows in parallel, followed by a round-down and a
//            saturation step.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_vec_mac #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int FRAC  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clk_en,
  input  logic                    i_start,
  input  logic [1:0]              i_mode,
  input  logic signed [WIDTH-1:0] i_a   [ROWS][COLS],
  input  logic signed [WIDTH-1:0] i_x   [COLS],
  input  logic signed [WIDTH-1:0] i_c   [ROWS],
  output logic signed [WIDTH-1:0] o_res [ROWS],
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_ovf
);

  // Accumulator holds COLS full products plus one guard bit for the c +/- acc step.
  localparam int ACC_W = 2*WIDTH + $clog2(COLS) + 1;
  localparam int CNT_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CNT_W-1:0] C_LAST_COL = CNT_W'(COLS - 1);

  // Saturation bounds expressed in accumulator width.
  localparam logic signed [ACC_W-1:0] C_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] C_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] C_RES_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] C_RES_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Operand snapshot taken at start acceptance.
  logic signed [WIDTH-1:0] r_a    [ROWS][COLS];
  logic signed [WIDTH-1:0] r_x    [COLS];
  logic signed [WIDTH-1:0] r_c    [ROWS];
  logic [1:0]              r_mode;

  logic [CNT_W-1:0]        r_col;
  logic signed [ACC_W-1:0] r_acc  [ROWS];
  logic signed [WIDTH-1:0] r_res  [ROWS];
  logic                    r_ovf;

  logic signed [ACC_W-1:0] w_acc_nxt [ROWS];
  logic signed [WIDTH-1:0] w_res     [ROWS];
  logic [ROWS-1:0]         w_sat;
  logic                    w_accept;

  // A new request is only taken when no operation is in flight.
  assign w_accept = i_clk_en && i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // State register; reset wins over the clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (i_clk_en) begin
      r_state <= w_next;
    end
  end

  // Next-state and status decode.
  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_ACC;
      end
      S_ACC: begin
        o_busy = 1'b1;
        if (r_col == C_LAST_COL) w_next = S_NORM;
      end
      S_NORM: begin
        o_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = i_start ? S_ACC : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture operands so later input changes cannot disturb the running operation.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_a    <= i_a;
      r_x    <= i_x;
      r_c    <= i_c;
      r_mode <= i_mode;
    end
  end

  // Column counter and per-row accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      for (int i = 0; i < ROWS; i++) r_acc[i] <= '0;
    end else if (i_clk_en) begin
      if (w_accept) begin
        r_col <= '0;
        for (int i = 0; i < ROWS; i++) r_acc[i] <= '0;
      end else if (r_state == S_ACC) begin
        r_col <= r_col + 1'b1;
        for (int i = 0; i < ROWS; i++) r_acc[i] <= w_acc_nxt[i];
      end
    end
  end

  // Result and overflow flag, updated only when normalisation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      for (int i = 0; i < ROWS; i++) r_res[i] <= '0;
    end else if (i_clk_en) begin
      if (w_accept) begin
        r_ovf <= 1'b0;
      end else if (r_state == S_NORM) begin
        r_ovf <= |w_sat;
        for (int i = 0; i < ROWS; i++) r_res[i] <= w_res[i];
      end
    end
  end

  // Per-row datapath: MAC term, offset combine, round-down and saturation.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_c_ext;
    logic signed [ACC_W-1:0]   w_t;
    logic signed [ACC_W-1:0]   w_sh;
    logic                      w_hi;
    logic                      w_lo;

    assign w_prod          = r_a[gi][r_col] * r_x[r_col];
    assign w_prod_ext      = {{(ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
    assign w_acc_nxt[gi]   = r_acc[gi] + w_prod_ext;

    // Offset aligned to the product's binary point (2*FRAC fractional bits).
    assign w_c_ext = {{(ACC_W-WIDTH){r_c[gi][WIDTH-1]}}, r_c[gi]} <<< FRAC;
    assign w_t     = (r_mode == 2'd1) ? (w_c_ext + r_acc[gi]) :
                     (r_mode == 2'd2) ? (w_c_ext - r_acc[gi]) :
                                        r_acc[gi];

    // Arithmetic shift drops FRAC bits, rounding toward minus infinity.
    assign w_sh  = w_t >>> FRAC;
    assign w_hi  = (w_sh > C_MAX);
    assign w_lo  = (w_sh < C_MIN);
    assign w_sat[gi] = w_hi | w_lo;
    assign w_res[gi] = w_hi ? C_RES_MAX :
                       w_lo ? C_RES_MIN :
                              w_sh[WIDTH-1:0];
  end : g_row

  assign o_res = r_res;
  assign o_ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_matrix_vec_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_vec_mac
// Purpose  : Self-checking bench for matrix_vec_mac: directed cases with
//            literal expectations, plus randomized traffic compared every
//            cycle against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_vec_mac;

  localparam int W = 16;
  localparam int R = 4;
  localparam int C = 4;
  localparam int F = 8;

  logic clk = 1'b0;
  logic rst, en, start;
  logic [1:0] mode;
  logic signed [W-1:0] a   [R][C];
  logic signed [W-1:0] x   [C];
  logic signed [W-1:0] cv  [R];
  logic signed [W-1:0] res [R];
  logic busy, done, ovf;
  logic chk_on = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matrix_vec_mac #(.WIDTH(W), .ROWS(R), .COLS(C), .FRAC(F)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_clk_en (en),
    .i_start  (start),
    .i_mode   (mode),
    .i_a      (a),
    .i_x      (x),
    .i_c      (cv),
    .o_res    (res),
    .o_busy   (busy),
    .o_done   (done),
    .o_ovf    (ovf)
  );

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_cnt = enabled edges left until the result appears; 0 means not busy.
  int m_cnt = 0;
  logic m_done = 1'b0;
  logic m_ovf = 1'b0;
  logic p_ovf;
  logic signed [W-1:0] m_res [R];
  logic signed [W-1:0] p_res [R];

  function automatic void predict();
    longint s, t, q;
    p_ovf = 1'b0;
    for (int i = 0; i < R; i++) begin
      s = 0;
      for (int k = 0; k < C; k++) s += longint'(a[i][k]) * longint'(x[k]);
      case (mode)
        2'd1:    t = longint'(cv[i]) * 256 + s;
        2'd2:    t = longint'(cv[i]) * 256 - s;
        default: t = s;
      endcase
      q = t >>> F;
      if (q > 32767) begin
        p_res[i] = 16'h7FFF; p_ovf = 1'b1;
      end else if (q < -32768) begin
        p_res[i] = 16'h8000; p_ovf = 1'b1;
      end else begin
        p_res[i] = q[15:0];
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_done = 1'b0; m_ovf = 1'b0;
      for (int i = 0; i < R; i++) m_res[i] = '0;
    end else if (en) begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1; m_ovf = p_ovf;
          for (int i = 0; i < R; i++) m_res[i] = p_res[i];
        end
      end else begin
        m_done = 1'b0;
        if (start) begin
          predict();
          m_cnt = C + 1;
          m_ovf = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk16("done", 16'(done), 16'(m_done));
      chk16("busy", 16'(busy), 16'(m_cnt > 0));
      chk16("ovf",  16'(ovf),  16'(m_ovf));
      for (int i = 0; i < R; i++) chk16($sformatf("res%0d", i), res[i], m_res[i]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_identity();
    for (int i = 0; i < R; i++)
      for (int k = 0; k < C; k++) a[i][k] = (i == k) ? 16'sh0100 : 16'sh0000;
    x[0] = 16'sh0100; x[1] = 16'sh0200; x[2] = 16'shFF00; x[3] = 16'sh0080;
    for (int i = 0; i < R; i++) cv[i] = 16'sh0100;
  endtask

  task automatic expect_res(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3, input logic eovf);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < R; i++) begin
      chk16($sformatf("%s_res%0d", tag, i), res[i], e[i]);
      chk16($sformatf("%s_model%0d", tag, i), m_res[i], e[i]);
    end
    chk16({tag, "_ovf"}, 16'(ovf), 16'(eovf));
  endtask

  // Called at a negedge with the DUT idle or in DONE. lat counts clock edges
  // starting with the accepting edge, up to the one that raises done.
  task automatic run_op(input int stall_at, output int lat);
    bit got = 0;
    start = 1'b1;
    lat = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
      if (stall_at >= 0 && lat == stall_at) begin
        en = 1'b0;
        a[1][1] = 16'sh1234;
        x[0]    = 16'sh0999;
        x[3]    = 16'sh7000;
      end
      if (stall_at >= 0 && lat == stall_at + 3) begin
        en = 1'b1;
        start = 1'b1;
      end
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) chkint("done_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    chk16("single_done_pulse", 16'(done), 16'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, last, cyc, pulses, d;
    rst = 1'b1; en = 1'b1; start = 1'b0; mode = 2'd0;
    for (int i = 0; i < R; i++) begin
      cv[i] = '0;
      for (int k = 0; k < C; k++) a[i][k] = '0;
    end
    for (int k = 0; k < C; k++) x[k] = '0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk16("rst_busy", 16'(busy), 16'd0);
    chk16("rst_done", 16'(done), 16'd0);
    expect_res("rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Identity and offset modes
    set_identity(); mode = 2'd0;
    run_op(-1, lat);
    chkint("ident_latency", lat, 6);
    expect_res("ident", 16'h0100, 16'h0200, 16'hFF00, 16'h0080, 1'b0);
    mode = 2'd1;
    run_op(-1, lat);
    expect_res("add", 16'h0200, 16'h0300, 16'h0000, 16'h0180, 1'b0);
    mode = 2'd2;
    run_op(-1, lat);
    expect_res("sub", 16'h0000, 16'hFF00, 16'h0200, 16'h0080, 1'b0);
    mode = 2'd3;
    run_op(-1, lat);
    expect_res("mode3", 16'h0100, 16'h0200, 16'hFF00, 16'h0080, 1'b0);

    // Saturation in both directions, then a clean run clears ovf
    mode = 2'd0;
    for (int i = 0; i < R; i++)
      for (int k = 0; k < C; k++) a[i][k] = 16'sh7FFF;
    for (int k = 0; k < C; k++) x[k] = 16'sh7FFF;
    run_op(-1, lat);
    expect_res("satpos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    for (int k = 0; k < C; k++) x[k] = 16'sh8000;
    run_op(-1, lat);
    expect_res("satneg", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1);
    set_identity();
    run_op(-1, lat);
    expect_res("clean", 16'h0100, 16'h0200, 16'hFF00, 16'h0080, 1'b0);

    // Stall mid-ACC, operand changes and a start pulse while busy
    set_identity(); mode = 2'd0;
    run_op(2, lat);
    chkint("stall_latency", lat, 9);
    expect_res("stall", 16'h0100, 16'h0200, 16'hFF00, 16'h0080, 1'b0);

    // Back-to-back with start held high
    set_identity(); mode = 2'd1;
    start = 1'b1; last = -1; cyc = 0; pulses = 0;
    repeat (40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (last >= 0) chkint("b2b_period", cyc - last, 6);
        else chkint("b2b_first", cyc, 6);
        last = cyc;
        pulses++;
      end
    end
    start = 1'b0;
    chkint("b2b_pulses", pulses, 6);
    repeat (8) @(negedge clk);

    // Reset during the second ACC cycle aborts the operation
    set_identity(); mode = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk16("abort_busy", 16'(busy), 16'd0);
    chk16("abort_done", 16'(done), 16'd0);
    expect_res("abort", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    d = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) d++;
    end
    chkint("abort_no_done", d, 0);

    // Randomized traffic: enables, starts, modes, operand churn, rare resets
    repeat (900) begin
      @(negedge clk);
      en    = ($urandom_range(0, 3) != 0);
      start = $urandom_range(0, 1) == 1;
      mode  = 2'($urandom_range(0, 3));
      rst   = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 2) == 0) begin
        bit big;
        int v;
        big = $urandom_range(0, 3) == 0;
        for (int i = 0; i < R; i++) begin
          for (int k = 0; k < C; k++) begin
            v = big ? int'($urandom) : ($urandom_range(0, 1023) - 512);
            a[i][k] = v[15:0];
          end
          v = big ? int'($urandom) : ($urandom_range(0, 4095) - 2048);
          cv[i] = v[15:0];
        end
        for (int k = 0; k < C; k++) begin
          v = big ? int'($urandom) : ($urandom_range(0, 2047) - 1024);
          x[k] = v[15:0];
        end
      end
    end
    rst = 1'b0; en = 1'b1; start = 1'b0;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
